// File: rtl/fetch_seq_if.sv
// fetch_seq_if: ROM/decoder-facing bus of the instruction-fetch stage.
// Ports: rom_data/bus/decoder controls in, rom_addr/pc/ir/exec/retired/halted out.
// master = fetch stage, slave = ROM + decoder + datapath side.
interface fetch_seq_if #(
  parameter int COUNT_W = 16
);
  // ROM and data bus
  logic [7:0]         rom_data;
  logic [7:0]         bus;
  // decoder control (meaningful only while exec is high)
  logic               loadBarIR;
  logic               assertBarRom;
  logic               doJump;
  // fetch stage outputs
  logic [7:0]         rom_addr;
  logic [7:0]         pc;
  logic [7:0]         ir;
  logic               exec;
  logic [COUNT_W-1:0] retired;
  logic               halted;

  modport master (
    input  rom_data, bus, loadBarIR, assertBarRom, doJump,
    output rom_addr, pc, ir, exec, retired, halted
  );

  modport slave (
    output rom_data, bus, loadBarIR, assertBarRom, doJump,
    input  rom_addr, pc, ir, exec, retired, halted
  );
endinterface

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch stage owning PC and IR, alternating FETCH/EXEC phases.
// Ports: clk, reset (sync, active-high), hold (freeze all state), f (fetch_seq_if.master).
// Optional FETCH_HALT_EN: executing 8'hFF latches halted and freezes the stage until reset.
module fetch_seq #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         COUNT_W  = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  fetch_seq_if.master  f
);

  typedef enum logic {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } state_t;

  state_t             state;
  logic [7:0]         pcQ;
  logic [7:0]         irQ;
  logic [COUNT_W-1:0] retiredQ;

  logic               frozen;
  logic               haltHit;
  logic [7:0]         pcInc;
  logic [7:0]         pcImm;

  // Plain increment for FETCH; EXEC only advances when the decoder
  // consumed the ROM immediate (assertBarRom low).
  assign pcInc = pcQ + 8'd1;
  assign pcImm = pcQ + {7'd0, ~f.assertBarRom};

`ifdef FETCH_HALT_EN
  logic haltedQ;
  // 8'hFF decodes to destination 7, which is otherwise unused: reuse as HALT.
  assign haltHit  = (irQ == 8'hFF);
  // Once halted, the stage behaves as if hold were stuck high.
  assign frozen   = hold | haltedQ;
  assign f.halted = haltedQ;
`else
  assign haltHit  = 1'b0;
  assign frozen   = hold;
  assign f.halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset dominates hold and abandons any instruction in flight.
      state    <= FETCH;
      pcQ      <= RESET_PC;
      irQ      <= 8'h00;
      retiredQ <= '0;
`ifdef FETCH_HALT_EN
      haltedQ  <= 1'b0;
`endif
    end else if (!frozen) begin
      case (state)
        FETCH: begin
          // Decoder controls are don't-care here.
          irQ   <= f.rom_data;
          pcQ   <= pcInc;
          state <= EXEC;
        end
        EXEC: begin
          // The halting EXEC still counts as a completed EXEC cycle.
          retiredQ <= retiredQ + {{(COUNT_W-1){1'b0}}, 1'b1};
          if (haltHit) begin
            // pc, ir and state hold; the halt flag freezes the stage afterwards.
`ifdef FETCH_HALT_EN
            haltedQ <= 1'b1;
`endif
          end else if (f.doJump) begin
            // Jump wins over an (illegal) simultaneous IR load: IR untouched.
            pcQ   <= f.bus;
            state <= FETCH;
          end else if (!f.loadBarIR) begin
            // IR reload: stay in EXEC so the new byte executes without a fetch.
            irQ   <= f.bus;
            pcQ   <= pcImm;
            state <= EXEC;
          end else begin
            pcQ   <= pcImm;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign f.rom_addr = pcQ;
  assign f.pc       = pcQ;
  assign f.ir       = irQ;
  assign f.exec     = (state == EXEC);
  assign f.retired  = retiredQ;

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

  logic clk;
  logic reset;
  logic hold;

  fetch_seq_if #(.COUNT_W(16)) fif ();

  fetch_seq #(.RESET_PC(8'h00), .COUNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .hold  (hold),
    .f     (fif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM image.
  logic [7:0] rom [256];
  assign fif.rom_data = rom[fif.rom_addr];

  typedef struct {
    logic [7:0]  pc;
    logic [7:0]  ir;
    logic        exec;
    logic [15:0] ret;
    logic        halted;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;

  // Architectural reference state.
  logic [7:0]  mPc     = 8'h00;
  logic [7:0]  mIr     = 8'h00;
  logic        mExec   = 1'b0;
  logic [15:0] mRet    = 16'h0000;
  logic        mHalted = 1'b0;

  // Reference model: what one clock does to the architectural state.
  task automatic modelStep(input logic r, input logic h, input logic lbi,
                           input logic abr, input logic dj, input logic [7:0] b);
    bit isHalt;
`ifdef FETCH_HALT_EN
    isHalt = (mIr == 8'hFF);
`else
    isHalt = 1'b0;
`endif
    if (r) begin
      mPc = 8'h00; mIr = 8'h00; mExec = 1'b0; mRet = 16'h0; mHalted = 1'b0;
    end else if (h || mHalted) begin
      // frozen
    end else if (!mExec) begin
      mIr   = rom[mPc];
      mPc   = mPc + 8'd1;
      mExec = 1'b1;
    end else begin
      mRet = mRet + 16'd1;
      if (isHalt) begin
        mHalted = 1'b1;
      end else if (dj) begin
        mPc   = b;
        mExec = 1'b0;
      end else begin
        if (!abr) mPc = mPc + 8'd1;
        if (!lbi) mIr = b;
        else      mExec = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic step(input logic r, input logic h, input logic lbi,
                      input logic abr, input logic dj, input logic [7:0] b);
    exp_t e;
    @(negedge clk);
    reset            = r;
    hold             = h;
    fif.loadBarIR    = lbi;
    fif.assertBarRom = abr;
    fif.doJump       = dj;
    fif.bus          = b;
    modelStep(r, h, lbi, abr, dj, b);
    e.pc = mPc; e.ir = mIr; e.exec = mExec; e.ret = mRet; e.halted = mHalted;
    expQ.push_back(e);
  endtask

  task automatic check8(input string name, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: after every rising edge, compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check8("pc",       {8'h00, fif.pc},       {8'h00, e.pc});
        check8("rom_addr", {8'h00, fif.rom_addr}, {8'h00, e.pc});
        check8("ir",       {8'h00, fif.ir},       {8'h00, e.ir});
        check8("exec",     {15'h0, fif.exec},     {15'h0, e.exec});
        check8("retired",  fif.retired,           e.ret);
        check8("halted",   {15'h0, fif.halted},   {15'h0, e.halted});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h00] = 8'h23;
    rom[8'h40] = 8'h11;
    reset = 1'b0; hold = 1'b0;
    fif.loadBarIR = 1'b1; fif.assertBarRom = 1'b1; fif.doJump = 1'b0; fif.bus = 8'h00;

    // Directed sequence from the bring-up plan.
    step(1, 0, 1, 1, 0, 8'h00);   // reset
    step(0, 0, 1, 1, 0, 8'h00);   // FETCH 0x23
    step(0, 0, 1, 1, 0, 8'h00);   // EXEC, no immediate: pc holds
    step(0, 0, 1, 1, 0, 8'h00);   // FETCH
    step(0, 0, 1, 0, 0, 8'h00);   // EXEC, immediate consumed
    step(0, 0, 1, 1, 0, 8'h00);   // FETCH
    step(0, 0, 1, 1, 1, 8'h40);   // EXEC jump 0x40
    step(0, 0, 1, 1, 0, 8'h00);   // FETCH from 0x40
    step(0, 0, 0, 1, 0, 8'h5A);   // EXEC IR reload 0x5A
    step(0, 0, 1, 1, 1, 8'hFF);   // EXEC of 0x5A: jump 0xFF
    step(0, 0, 1, 1, 0, 8'h00);   // FETCH at 0xFF: pc wraps to 0x00
    step(0, 1, 0, 0, 1, 8'h77);   // hold mid-EXEC x3
    step(0, 1, 0, 0, 1, 8'h77);
    step(0, 1, 0, 0, 1, 8'h77);
    step(1, 1, 1, 1, 0, 8'h00);   // reset beats hold
    step(0, 0, 0, 1, 1, 8'h33);   // FETCH ignores decoder inputs
    step(0, 0, 0, 0, 1, 8'h66);   // illegal jump+load: jump wins

    // Randomized traffic, including occasional reset/hold and ROM 0xFF bytes.
    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 5) != 0),
           1'($urandom),
           ($urandom_range(0, 5) == 0),
           8'($urandom));
    end
    step(1, 0, 1, 1, 0, 8'h00);

    // Let the monitor drain the last expectation.
    @(posedge clk);
    #2;
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, 0 expected", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
